// File: rtl/button_pkg.sv
// Shared definitions for the pushbutton debounce stage.
// Tick defaults assume the 1 kHz clock divider output.
package button_pkg;

  localparam logic [2:0] STATE_IDLE         = 3'd0;
  localparam logic [2:0] STATE_PRESS_WAIT   = 3'd1;
  localparam logic [2:0] STATE_HELD         = 3'd2;
  localparam logic [2:0] STATE_LONG_HELD    = 3'd3;
  localparam logic [2:0] STATE_RELEASE_WAIT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE         = STATE_IDLE,
    S_PRESS_WAIT   = STATE_PRESS_WAIT,
    S_HELD         = STATE_HELD,
    S_LONG_HELD    = STATE_LONG_HELD,
    S_RELEASE_WAIT = STATE_RELEASE_WAIT
  } state_t;

  localparam int DEFAULT_DEBOUNCE_TICKS = 30;
  localparam int DEFAULT_LONG_TICKS     = 1000;
  localparam int DEFAULT_REPEAT_TICKS   = 200;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button: synchroniser, debounce/hold FSM and shared tick counter.
// Auto-repeat is built only when BUTTON_AUTOREPEAT_EN is defined.
module button_debounce_channel
  import button_pkg::*;
#(
  parameter int ACTIVE_LOW     = 1,
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter int LONG_TICKS     = DEFAULT_LONG_TICKS,
  parameter int REPEAT_TICKS   = DEFAULT_REPEAT_TICKS
) (
  input  logic reset,
  input  logic clock_divider_out,
  input  logic button_raw,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int MAXT = max3(DEBOUNCE_TICKS, LONG_TICKS, REPEAT_TICKS);
  localparam int W = $clog2(MAXT + 1);
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] DEB = W'(DEBOUNCE_TICKS);
  localparam logic [W-1:0] LNG = W'(LONG_TICKS);
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

  logic sync_a;
  logic sync_b;
  logic s;
  state_t state;
  state_t state_n;
  state_t ret;
  state_t ret_n;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_n;
  logic [W-1:0] cnt_inc;
  logic press_n;
  logic release_n;
  logic long_n;

  // Flops start at the released level so reset never looks like a press.
  always_ff @(posedge clock_divider_out or posedge reset) begin
    if (reset) begin
      sync_a <= IDLE_LVL;
      sync_b <= IDLE_LVL;
    end else begin
      sync_a <= button_raw;
      sync_b <= sync_a;
    end
  end

  assign s = (ACTIVE_LOW != 0) ? ~sync_b : sync_b;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + ONE;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [W-1:0] RPT = W'(REPEAT_TICKS);
  logic repeat_n;
`endif

  always_comb begin
    state_n   = state;
    ret_n     = ret;
    cnt_n     = cnt;
    press_n   = 1'b0;
    release_n = 1'b0;
    long_n    = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
    repeat_n  = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (s) begin
          if (ONE >= DEB) begin
            state_n = S_HELD;
            press_n = 1'b1;
            cnt_n   = '0;
          end else begin
            state_n = S_PRESS_WAIT;
            cnt_n   = ONE;
          end
        end
      end
      S_PRESS_WAIT: begin
        if (!s) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt_inc >= DEB) begin
          state_n = S_HELD;
          press_n = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_HELD, S_LONG_HELD: begin
        if (!s) begin
          ret_n = state;
          if (ONE >= DEB) begin
            state_n   = S_IDLE;
            release_n = 1'b1;
            cnt_n     = '0;
          end else begin
            state_n = S_RELEASE_WAIT;
            cnt_n   = ONE;
          end
        end else if (state == S_HELD) begin
          if (cnt_inc >= LNG) begin
            state_n = S_LONG_HELD;
            long_n  = 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end else begin
`ifdef BUTTON_AUTOREPEAT_EN
          if (cnt_inc >= RPT) begin
            repeat_n = 1'b1;
            cnt_n    = '0;
          end else begin
            cnt_n = cnt_inc;
          end
`else
          cnt_n = '0;
`endif
        end
      end
      S_RELEASE_WAIT: begin
        // A bounce back to pressed restarts the hold timing.
        if (s) begin
          state_n = ret;
          cnt_n   = '0;
        end else if (cnt_inc >= DEB) begin
          state_n   = S_IDLE;
          release_n = 1'b1;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_divider_out or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      ret           <= S_IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state         <= state_n;
      ret           <= ret_n;
      cnt           <= cnt_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      long_pulse    <= long_n;
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  always_ff @(posedge clock_divider_out or posedge reset) begin
    if (reset) repeat_pulse <= 1'b0;
    else       repeat_pulse <= repeat_n;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

  assign pressed = (state == S_HELD) ||
                   (state == S_LONG_HELD) ||
                   (state == S_RELEASE_WAIT);

endmodule

// File: rtl/button_debouncer.sv
// Debounce and press/release/long/repeat event generation per button.
// Optional auto-repeat: define BUTTON_AUTOREPEAT_EN.
module button_debouncer
  import button_pkg::*;
#(
  parameter int N_BUTTONS      = 2,
  parameter int ACTIVE_LOW     = 1,
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter int LONG_TICKS     = DEFAULT_LONG_TICKS,
  parameter int REPEAT_TICKS   = DEFAULT_REPEAT_TICKS
) (
  input  logic                 reset,
  input  logic                 clock_divider_out,
  input  logic [N_BUTTONS-1:0] button_raw,
  output logic [N_BUTTONS-1:0] pressed,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] release_pulse,
  output logic [N_BUTTONS-1:0] long_pulse,
  output logic [N_BUTTONS-1:0] repeat_pulse
);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    button_debounce_channel #(
      .ACTIVE_LOW    (ACTIVE_LOW),
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .LONG_TICKS    (LONG_TICKS),
      .REPEAT_TICKS  (REPEAT_TICKS)
    ) u_ch (
      .reset            (reset),
      .clock_divider_out(clock_divider_out),
      .button_raw       (button_raw[i]),
      .pressed          (pressed[i]),
      .press_pulse      (press_pulse[i]),
      .release_pulse    (release_pulse[i]),
      .long_pulse       (long_pulse[i]),
      .repeat_pulse     (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: run-length reference model,
// per-cycle expected vectors queued at each edge and checked at negedge.
module tb_button_debouncer;

  localparam int D = 4;
  localparam int L = 10;
  localparam int R = 3;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [1:0] pr;
    logic [1:0] pp;
    logic [1:0] rp;
    logic [1:0] lp;
    logic [1:0] rep;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] raw = 2'b11;
  logic [1:0] pressed;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;
  logic [1:0] long_pulse;
  logic [1:0] repeat_pulse;

  button_debouncer #(
    .N_BUTTONS     (2),
    .ACTIVE_LOW    (1),
    .DEBOUNCE_TICKS(D),
    .LONG_TICKS    (L),
    .REPEAT_TICKS  (R)
  ) dut (
    .reset            (reset),
    .clock_divider_out(clk),
    .button_raw       (raw),
    .pressed          (pressed),
    .press_pulse      (press_pulse),
    .release_pulse    (release_pulse),
    .long_pulse       (long_pulse),
    .repeat_pulse     (repeat_pulse)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Model: pipeline of raw samples, plus for each channel the debounced
  // level, how long s has disagreed with it, and ticks held since the
  // last press / long event / repeat.
  bit h1[2];
  bit h2[2];
  bit lvl[2];
  int run[2];
  int age[2];
  bit lng[2];

  task automatic chk(input string nm, input int c,
                     input logic [1:0] act, input logic [1:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle=%0d actual=%b required=%b", nm, c, act, req);
  endtask

  task automatic model_step(input logic [1:0] r, input logic rst);
    exp_t e;
    cyc++;
    e.cyc = cyc;
    e.pr = '0; e.pp = '0; e.rp = '0; e.lp = '0; e.rep = '0;
    for (int c = 0; c < 2; c++) begin
      bit s;
      if (rst) begin
        h1[c] = 0; h2[c] = 0; lvl[c] = 0;
        run[c] = 0; age[c] = 0; lng[c] = 0;
      end else begin
        s = h2[c];
        h2[c] = h1[c];
        h1[c] = ~r[c];
        if (s != lvl[c]) begin
          run[c]++;
          if (run[c] == D) begin
            lvl[c] = s;
            if (s) e.pp[c] = 1'b1;
            else   e.rp[c] = 1'b1;
            run[c] = 0; age[c] = 0; lng[c] = 0;
          end
        end else begin
          if (lvl[c]) begin
            if (run[c] > 0) age[c] = 0;
            else begin
              age[c]++;
              if (!lng[c] && age[c] == L) begin
                e.lp[c] = 1'b1; lng[c] = 1; age[c] = 0;
              end else if (lng[c] && AUTOREP && age[c] == R) begin
                e.rep[c] = 1'b1; age[c] = 0;
              end
            end
          end
          run[c] = 0;
        end
      end
      e.pr[c] = lvl[c];
    end
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic [1:0] r);
    raw = r;
    @(posedge clk);
    model_step(r, reset);
    @(negedge clk);
  endtask

  task automatic hold(input logic [1:0] r, input int n);
    for (int i = 0; i < n; i++) tick(r);
  endtask

  task automatic do_reset(input logic [1:0] r);
    #2 reset = 1'b1;
    #1;
    chk("rst_pressed", cyc, pressed, 2'b00);
    chk("rst_press", cyc, press_pulse, 2'b00);
    chk("rst_release", cyc, release_pulse, 2'b00);
    chk("rst_long", cyc, long_pulse, 2'b00);
    chk("rst_repeat", cyc, repeat_pulse, 2'b00);
    hold(r, 2);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("pressed", mon_e.cyc, pressed, mon_e.pr);
      chk("press_pulse", mon_e.cyc, press_pulse, mon_e.pp);
      chk("release_pulse", mon_e.cyc, release_pulse, mon_e.rp);
      chk("long_pulse", mon_e.cyc, long_pulse, mon_e.lp);
      chk("repeat_pulse", mon_e.cyc, repeat_pulse, mon_e.rep);
    end
  end

  initial begin
    logic [1:0] tgt;
    logic [1:0] r;
    int len;
    for (int c = 0; c < 2; c++) begin
      h1[c] = 0; h2[c] = 0; lvl[c] = 0;
      run[c] = 0; age[c] = 0; lng[c] = 0;
    end
    #1;
    chk("init_pressed", 0, pressed, 2'b00);
    chk("init_press", 0, press_pulse, 2'b00);
    chk("init_repeat", 0, repeat_pulse, 2'b00);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Clean press, long hold and release on channel 0.
    hold(2'b10, 20);
    hold(2'b11, 10);
    // Press glitch, then a real press.
    hold(2'b10, 3);
    hold(2'b11, 1);
    hold(2'b10, 12);
    hold(2'b11, 10);
    // Long hold with repeats.
    hold(2'b10, 30);
    hold(2'b11, 10);
    // Release bounce while in HELD, then a clean release.
    hold(2'b10, 8);
    hold(2'b11, 2);
    hold(2'b10, 5);
    hold(2'b11, 10);
    // Release bounce while in LONG_HELD.
    hold(2'b10, 20);
    hold(2'b11, 2);
    hold(2'b10, 8);
    hold(2'b11, 10);
    // Reset during PRESS_WAIT and during HELD with the button kept down.
    hold(2'b10, 3);
    do_reset(2'b10);
    hold(2'b10, 10);
    do_reset(2'b10);
    hold(2'b10, 10);
    hold(2'b11, 10);
    // Both buttons together, released at different times.
    hold(2'b00, 25);
    hold(2'b10, 7);
    hold(2'b11, 10);

    // Random segments: held targets with occasional bounce and resets.
    for (int sgi = 0; sgi < 200; sgi++) begin
      tgt = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 30);
      if ($urandom_range(0, 39) == 0) do_reset(tgt);
      for (int i = 0; i < len; i++) begin
        r = tgt;
        for (int c = 0; c < 2; c++)
          if ($urandom_range(0, 7) == 0) r[c] = ~tgt[c];
        tick(r);
      end
    end

    hold(2'b11, 10);
    @(negedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Per-button debounce and event-generation stage. It sits directly upstream of the PMOD LED button counter and replaces that counter's ad-hoc debounce state machine.
- Clocked by the slow tick from the clock divider (nominal 1 kHz, 1 ms period).
- Turns raw active-low pushbutton pins into:
  - a clean held level;
  - single-cycle press, release, long-press and optional auto-repeat pulses.
- The counter stage samples these pulses through its own edge detector in the CLK domain.

Parameters:
- N_BUTTONS, 2, number of independent button channels.
- ACTIVE_LOW, 1, 1 means raw pin low = pressed; 0 means raw pin high = pressed.
- DEBOUNCE_TICKS, 30, consecutive stable ticks required to accept a press or a release (minimum 1).
- LONG_TICKS, 1000, ticks after press_pulse until long_pulse.
- REPEAT_TICKS, 200, tick period of repeat_pulse while long-held (used only with the macro).

Ports:
- reset  input  1  reset, asynchronous, active-high.
- clock_divider_out  input  1  clock, slow tick from the clock divider, all logic on rising edge.
- button_raw  input  N_BUTTONS  raw pushbutton pins, asynchronous to the clock.
- pressed  output  N_BUTTONS  debounced level, 1 = button held.
- press_pulse  output  N_BUTTONS  one-cycle pulse on an accepted press.
- release_pulse  output  N_BUTTONS  one-cycle pulse on an accepted release.
- long_pulse  output  N_BUTTONS  one-cycle pulse when a held button reaches LONG_TICKS.
- repeat_pulse  output  N_BUTTONS  one-cycle auto-repeat pulse; tied 0 when the macro is absent.

Behaviour:
- Input conditioning, per channel:
  - 2-flop synchroniser, then polarity normalisation to s (1 = pressed).
  - Synchroniser flops reset to the released level.
- Reset:
  - All outputs 0.
  - All counters 0.
  - All channels in IDLE.
  - Reset is honoured mid-operation; no pulse is emitted because of reset.
- States per channel: IDLE, PRESS_WAIT, HELD, LONG_HELD, RELEASE_WAIT.
- IDLE:
  - s=1 -> PRESS_WAIT, with cnt=1.
- PRESS_WAIT:
  - s=0 -> IDLE and clear cnt. This is a bounce; no pulse.
  - s=1 and cnt reaches DEBOUNCE_TICKS -> HELD, pulse press_pulse, set pressed, clear cnt.
- HELD:
  - s=1: cnt increments.
  - cnt reaches LONG_TICKS -> LONG_HELD, pulse long_pulse, clear cnt.
  - s=0 -> RELEASE_WAIT, with cnt=1 and ret=HELD.
- LONG_HELD:
  - s=1: cnt counts, used for repeat only, and wraps at REPEAT_TICKS.
  - s=0 -> RELEASE_WAIT, with ret=LONG_HELD.
- RELEASE_WAIT:
  - s=1 -> return to ret. This is a bounce.
    - The hold counter restarts from 0.
    - pressed stays 1.
    - No pulse.
  - s=0 and cnt reaches DEBOUNCE_TICKS -> IDLE, pulse release_pulse, clear pressed, in the same cycle.
- Latency, with edge 1 as the first rising edge sampling raw asserted and raw held stable:
  - s is high from edge 2.
  - press_pulse and pressed rise at edge 1+DEBOUNCE_TICKS+1 = DEBOUNCE_TICKS+2.
  - Release is symmetric.
- Pulse width is exactly one clock_divider_out cycle.
- Event ordering:
  - press_pulse and release_pulse are never high together on one channel.
  - A press is always followed by exactly one release before the next press.
- Counter width is $clog2(max(DEBOUNCE_TICKS, LONG_TICKS, REPEAT_TICKS)+1).
  - cnt saturates rather than wrapping, except for the repeat wrap.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.

Optional Feature:
- Macro: BUTTON_AUTOREPEAT_EN.
- Defined:
  - In LONG_HELD, repeat_pulse fires once every REPEAT_TICKS ticks.
  - The first repeat_pulse fires REPEAT_TICKS ticks after long_pulse.
  - No repeat fires in the cycle of the release transition.
- Not defined:
  - repeat_pulse is constant 0.
  - No repeat counter logic is synthesised.
  - LONG_HELD holds cnt at 0.

Decomposition:
- Package button_pkg holds:
  - state encoding localparams STATE_IDLE, STATE_PRESS_WAIT, STATE_HELD, STATE_LONG_HELD, STATE_RELEASE_WAIT (3 bits);
  - the default tick constants for the 1 kHz tick.
- Sub-module button_debounce_channel implements:
  - one synchroniser, FSM and counter, with scalar ports.
- The top level instantiates it N_BUTTONS times in a generate loop.

Test Plan:
All scenarios use DEBOUNCE_TICKS=4, LONG_TICKS=10, REPEAT_TICKS=3, ACTIVE_LOW=1.
1. button_raw[0] driven 0 and held -> press_pulse[0] high for one cycle at edge 6, pressed[0]=1 from edge 6; other outputs stay 0.
2. Raw 0 for 3 ticks, then 1, then 0 held -> no pulse during the glitch; press_pulse fires 6 edges after the final 0.
3. Hold pressed -> long_pulse exactly 10 ticks after press_pulse. With the macro, repeat_pulse follows at +3, +6, +9. Without the macro, repeat_pulse stays 0.
4. Release with a 2-tick bounce back to pressed -> pressed stays 1 with no pulse. A clean release then gives release_pulse and pressed=0 at edge 6 after the release.
5. Assert reset in PRESS_WAIT and in HELD -> all outputs 0 immediately with no release_pulse. With the button still held after reset, press_pulse fires 6 edges after deassertion.
6. Both buttons pressed on the same edge -> press_pulse=2'b11 in the same cycle; independent long and release timing per channel.
